// File: rtl/search_step_supervisor.sv
// -----------------------------------------------------------------------------
// search_step_supervisor
//
// Run-control sequencer for the maze-search movement path. While idle it holds
// the search FSM in reset. A start command releases that reset. Each non-zero
// movement code is then turned into one timed motor pulse, followed by a settle
// window. The search ends on goal detection, on abort, or when the step budget
// is exhausted.
//
// Parameters
//   STEP_CYCLES    cycles a movement code is held on motor_cmd (>= 1)
//   SETTLE_CYCLES  idle cycles after each pulse (>= 1)
//   CNT_W          width of the step counter
//   MAX_STEPS      step budget, 1 .. 2**CNT_W-1
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            begin a new search (sampled in IDLE/DONE/TIMEOUT)
//   abort            cancel an active search
//   goal             target-detected flag
//   movement_sel_in  movement code from the search FSM, 4'b0000 = no move
//   machine_rst      reset to the search FSM, high when not searching
//   motor_cmd        registered movement pulse to the motor driver
//   step_count       pulses issued in the current/last search
//   busy             high in LOAD/MOVE/SETTLE
//   done             high in DONE
//   timeout          high in TIMEOUT
// -----------------------------------------------------------------------------
module search_step_supervisor #(
   parameter int STEP_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8,
   parameter int MAX_STEPS     = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             goal,
   input  logic [3:0]       movement_sel_in,
   output logic             machine_rst,
   output logic [3:0]       motor_cmd,
   output logic [CNT_W-1:0] step_count,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   // The timer only ever has to hold the larger reload value.
   localparam int TMR_MAX = ((STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES) - 1;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] STEP_LOAD   = TMR_W'(STEP_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_STEPS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_MOVE    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_DONE    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [3:0]       motor_cmd_r, motor_cmd_nxt_s;
   logic [CNT_W-1:0] step_count_r, step_count_nxt_s;
   logic [TMR_W-1:0] timer_r, timer_nxt_s;

   // State, pulse, counter and timer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         motor_cmd_r  <= 4'b0000;
         step_count_r <= CNT_ZERO;
         timer_r      <= TMR_ZERO;
      end else begin
         state_r      <= state_nxt_s;
         motor_cmd_r  <= motor_cmd_nxt_s;
         step_count_r <= step_count_nxt_s;
         timer_r      <= timer_nxt_s;
      end
   end

   // Next-state logic. Within each state abort outranks goal, and goal
   // outranks timer expiry and the budget check.
   always_comb begin
      state_nxt_s      = state_r;
      motor_cmd_nxt_s  = motor_cmd_r;
      step_count_nxt_s = step_count_r;
      timer_nxt_s      = timer_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_TIMEOUT: begin
            motor_cmd_nxt_s = 4'b0000;
            if (start && !abort) begin
               state_nxt_s      = ST_LOAD;
               step_count_nxt_s = CNT_ZERO;
            end else begin
               // Hold the state; step_count stays readable.
               state_nxt_s = state_r;
            end
         end
         ST_LOAD: begin
            motor_cmd_nxt_s = 4'b0000;
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (goal) begin
               state_nxt_s = ST_DONE;
            end else if (movement_sel_in != 4'b0000) begin
               state_nxt_s      = ST_MOVE;
               motor_cmd_nxt_s  = movement_sel_in;
               step_count_nxt_s = step_count_r + CNT_ONE;
               timer_nxt_s      = STEP_LOAD;
            end else begin
               // Zero code means no move, so wait here without counting a step.
               state_nxt_s = ST_LOAD;
            end
         end
         ST_MOVE: begin
            // motor_cmd holds the latched code; movement_sel_in is ignored here.
            if (abort) begin
               state_nxt_s     = ST_IDLE;
               motor_cmd_nxt_s = 4'b0000;
            end else if (goal) begin
               state_nxt_s     = ST_DONE;
               motor_cmd_nxt_s = 4'b0000;
            end else if (timer_r == TMR_ZERO) begin
               state_nxt_s     = ST_SETTLE;
               motor_cmd_nxt_s = 4'b0000;
               timer_nxt_s     = SETTLE_LOAD;
            end else begin
               timer_nxt_s = timer_r - TMR_ONE;
            end
         end
         ST_SETTLE: begin
            motor_cmd_nxt_s = 4'b0000;
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (goal) begin
               state_nxt_s = ST_DONE;
            end else if (timer_r == TMR_ZERO) begin
               // The budget is checked only here, so step_count can never pass
               // CNT_MAX.
               if (step_count_r == CNT_MAX) begin
                  state_nxt_s = ST_TIMEOUT;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               timer_nxt_s = timer_r - TMR_ONE;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            motor_cmd_nxt_s = 4'b0000;
            timer_nxt_s     = TMR_ZERO;
         end
      endcase
   end

   // Moore status outputs decoded straight from the state register.
   assign machine_rst = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_TIMEOUT);
   assign busy        = (state_r == ST_LOAD) || (state_r == ST_MOVE) || (state_r == ST_SETTLE);
   assign done        = (state_r == ST_DONE);
   assign timeout     = (state_r == ST_TIMEOUT);
   assign motor_cmd   = motor_cmd_r;
   assign step_count  = step_count_r;

endmodule
